// File: rtl/stack_multi_sequencer.sv
// stack_multi_sequencer: walks a Thumb PUSH/POP register list between the register file and data memory.
module stack_multi_sequencer #(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_pop,
  input  logic [7:0]        cmd_list,
  input  logic              cmd_extra,
  input  logic [DATA_W-1:0] sp_cur,
  output logic [3:0]        rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [3:0]        rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_sp_wr_en,
  output logic [DATA_W-1:0] rf_sp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_value,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, RDSEL, STORE, LOAD, WB, SPUPD, DONE} state_t;
  state_t state, nxt;
  logic [7:0] rem, rem_nxt;
  logic ext, pop_q, cap_v, cur_ext, last;
  logic [2:0] idx;
  logic [3:0] n_q, n_in;
  logic [DATA_W-1:0] sp_q, base_q, addr_q, wdata_q, data_q, base_in;
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (rem[i]) idx = 3'(i);
  end
  assign cur_ext = rem == 8'd0;
  assign rem_nxt = rem & ~(8'd1 << idx);
  assign last    = cur_ext || (rem_nxt == 8'd0 && !ext);
  assign n_in    = 4'($countones(cmd_list)) + {3'd0, cmd_extra};
  assign base_in = cmd_pop ? sp_cur : sp_cur - DATA_W'(STEP * n_in);
  // An empty list still spends one cycle in SPUPD (with the strobe gated) so done lands 2 cycles after acceptance.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cmd_valid) nxt = n_in == 4'd0 ? SPUPD : cmd_pop ? LOAD : RDSEL;
      RDSEL:   nxt = STORE;
      STORE:   if (mem_ready) nxt = last ? SPUPD : RDSEL;
      LOAD:    if (mem_ready) nxt = WB;
      WB:      nxt = last ? SPUPD : LOAD;
      SPUPD:   nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      ext     <= 1'b0;
      pop_q   <= 1'b0;
      cap_v   <= 1'b0;
      n_q     <= '0;
      sp_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (!stall_i) begin
      state <= nxt;
      if (state == IDLE && cmd_valid) begin
        rem    <= cmd_list;
        ext    <= cmd_extra;
        pop_q  <= cmd_pop;
        n_q    <= n_in;
        sp_q   <= sp_cur;
        base_q <= base_in;
        addr_q <= base_in;
      end
      if (state == STORE) begin
        wdata_q <= mem_wdata;
        cap_v   <= !mem_ready;
      end
      if (state == LOAD && mem_ready) data_q <= mem_rdata;
      if ((state == STORE && mem_ready) || state == WB) begin
        addr_q <= addr_q + DATA_W'(STEP);
        if (cur_ext) ext <= 1'b0;
        else rem <= rem_nxt;
      end
    end
  end
  assign cmd_ready   = state == IDLE;
  assign rf_rd_sel   = state == RDSEL ? (cur_ext ? 4'he : {1'b0, idx}) : 4'd0;
  assign mem_req     = state == STORE || state == LOAD;
  assign mem_we      = state == STORE;
  assign mem_addr    = mem_req ? addr_q : '0;
  assign mem_wdata   = mem_we ? (cap_v ? wdata_q : rf_rd_data) : '0;
  assign rf_wr_en    = state == WB && !cur_ext;
  assign rf_wr_sel   = rf_wr_en ? {1'b0, idx} : 4'd0;
  assign rf_wr_data  = rf_wr_en ? data_q : '0;
  assign pc_load     = state == WB && cur_ext;
  assign pc_value    = pc_load ? data_q : '0;
  assign rf_sp_wr_en = state == SPUPD && n_q != 4'd0;
  assign rf_sp_data  = rf_sp_wr_en ? (pop_q ? sp_q + DATA_W'(STEP * n_q) : base_q) : '0;
  assign done        = state == DONE;
endmodule

// File: tb/tb_stack_multi_sequencer.sv
// tb_stack_multi_sequencer: directed PUSH/POP scenarios against hand-computed transfers.
module tb_stack_multi_sequencer;
  logic clk = 0, rst = 1, stall_i = 0, cmd_valid = 0, cmd_pop = 0, cmd_extra = 0;
  logic [7:0] cmd_list = 0;
  logic [31:0] sp_cur = 0, rf_rd_data = 0, mem_rdata;
  logic cmd_ready, rf_wr_en, rf_sp_wr_en, mem_req, mem_we, mem_ready, pc_load, done;
  logic [3:0] rf_rd_sel, rf_wr_sel;
  logic [31:0] rf_wr_data, rf_sp_data, mem_addr, mem_wdata, pc_value;
  int checks = 0, errors = 0, wait_n = 0, wcnt = 0;
  int st_cnt = 0, wr_cnt = 0, sp_cnt = 0, pc_cnt = 0, done_cnt = 0, req_cyc = 0;
  logic [31:0] st_addr [16], st_data [16], wr_data [16], sp_last = 0, pc_last = 0;
  logic [3:0] wr_sel [16];

  stack_multi_sequencer dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pop(cmd_pop), .cmd_list(cmd_list), .cmd_extra(cmd_extra), .sp_cur(sp_cur),
    .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .rf_wr_data(rf_wr_data), .rf_sp_wr_en(rf_sp_wr_en), .rf_sp_data(rf_sp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_value(pc_value),
    .done(done)
  );

  always #5 clk = ~clk;

  // Register file returns r<sel> = 0xA000_000<sel> one cycle later, holding during stalls.
  always @(posedge clk) if (!stall_i) rf_rd_data <= 32'hA000_0000 | {28'd0, rf_rd_sel};
  always @(posedge clk)
    if (rst || !mem_req || (mem_ready && !stall_i)) wcnt <= 0;
    else if (!stall_i) wcnt <= wcnt + 1;
  assign mem_ready = mem_req && wcnt >= wait_n;
  assign mem_rdata = mem_addr == 32'h1FF2 ? 32'h11 : mem_addr == 32'h1FF6 ? 32'h2001 : mem_addr + 32'h100;

  always @(negedge clk) if (!rst && !stall_i) begin
    if (mem_req) req_cyc++;
    if (mem_req && mem_ready && mem_we) begin
      st_addr[st_cnt] = mem_addr;
      st_data[st_cnt] = mem_wdata;
      st_cnt++;
    end
    if (rf_wr_en) begin
      wr_sel[wr_cnt] = rf_wr_sel;
      wr_data[wr_cnt] = rf_wr_data;
      wr_cnt++;
    end
    if (rf_sp_wr_en) begin sp_cnt++; sp_last = rf_sp_data; end
    if (pc_load) begin pc_cnt++; pc_last = pc_value; end
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic pop, input logic [7:0] list, input logic extra, input logic [31:0] sp);
    cmd_pop = pop; cmd_list = list; cmd_extra = extra; sp_cur = sp; cmd_valid = 1;
    tick;
    cmd_valid = 0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 100) begin tick; k++; end
  endtask

  int k, req0, i;
  initial begin
    tick; tick;
    rst = 0;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_rd_sel", 32'(rf_rd_sel), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sp_wr", 32'(rf_sp_wr_en), 0);
    // 1: PUSH {r0,r2,LR}
    issue(0, 8'b0000_0101, 1, 32'h1FFE);
    wait_done(k);
    chk("t1_latency", 32'(k), 7);
    tick;
    chk("t1_st_cnt", 32'(st_cnt), 3);
    chk("t1_a0", st_addr[0], 32'h1FF2);
    chk("t1_d0", st_data[0], 32'hA000_0000);
    chk("t1_a1", st_addr[1], 32'h1FF6);
    chk("t1_d1", st_data[1], 32'hA000_0002);
    chk("t1_a2", st_addr[2], 32'h1FFA);
    chk("t1_d2", st_data[2], 32'hA000_000E);
    chk("t1_sp", sp_last, 32'h1FF2);
    chk("t1_done", 32'(done_cnt), 1);
    // 2: POP {r1,PC}
    issue(1, 8'b0000_0010, 1, 32'h1FF2);
    wait_done(k);
    chk("t2_latency", 32'(k), 5);
    tick;
    chk("t2_wr_cnt", 32'(wr_cnt), 1);
    chk("t2_wr_sel", 32'(wr_sel[0]), 1);
    chk("t2_wr_data", wr_data[0], 32'h11);
    chk("t2_pc_cnt", 32'(pc_cnt), 1);
    chk("t2_pc", pc_last, 32'h2001);
    chk("t2_sp", sp_last, 32'h1FFA);
    chk("t2_sp_cnt", 32'(sp_cnt), 2);
    // 3: empty list
    req0 = req_cyc;
    issue(0, 8'd0, 0, 32'h4000);
    chk("t3_busy", 32'(cmd_ready), 0);
    wait_done(k);
    chk("t3_latency", 32'(k), 1);
    tick;
    chk("t3_no_req", 32'(req_cyc - req0), 0);
    chk("t3_no_sp", 32'(sp_cnt), 2);
    chk("t3_no_wr", 32'(wr_cnt), 1);
    chk("t3_done", 32'(done_cnt), 3);
    chk("t3_idle", 32'(cmd_ready), 1);
    // 4: PUSH {r7} with slow memory and a stall mid-store
    wait_n = 3;
    issue(0, 8'h80, 0, 32'h1000);
    tick;
    chk("t4_req", 32'(mem_req), 1);
    chk("t4_addr", mem_addr, 32'h0FFC);
    chk("t4_wdata", mem_wdata, 32'hA000_0007);
    stall_i = 1;
    tick; tick;
    chk("t4_stall_addr", mem_addr, 32'h0FFC);
    chk("t4_stall_wdata", mem_wdata, 32'hA000_0007);
    chk("t4_stall_req", 32'(mem_req), 1);
    stall_i = 0;
    wait_done(k);
    chk("t4_done_seen", 32'(done), 1);
    tick;
    chk("t4_st_cnt", 32'(st_cnt), 4);
    chk("t4_d", st_data[3], 32'hA000_0007);
    chk("t4_a", st_addr[3], 32'h0FFC);
    chk("t4_sp", sp_last, 32'h0FFC);
    chk("t4_done", 32'(done_cnt), 4);
    // 5: reset during the second load of POP {r0-r3}
    wait_n = 1;
    issue(1, 8'h0F, 0, 32'h3000);
    for (i = 0; i < 50 && !(wr_cnt == 2 && mem_req && !mem_we); i++) tick;
    chk("t5_reach_load2", 32'(wr_cnt == 2 && mem_req && !mem_we), 1);
    rst = 1;
    tick;
    rst = 0;
    chk("t5_idle", 32'(cmd_ready), 1);
    chk("t5_req_off", 32'(mem_req), 0);
    tick; tick; tick;
    chk("t5_no_sp", 32'(sp_cnt), 3);
    chk("t5_no_done", 32'(done_cnt), 4);
    chk("t5_wr_cnt", 32'(wr_cnt), 2);
    chk("t5_wr_sel", 32'(wr_sel[1]), 0);
    chk("t5_wr_data", wr_data[1], 32'h3100);
    // 6: base wraps below zero
    wait_n = 0;
    issue(0, 8'b0000_0111, 0, 32'h4);
    wait_done(k);
    chk("t6_latency", 32'(k), 7);
    tick;
    chk("t6_a0", st_addr[4], 32'hFFFF_FFF8);
    chk("t6_a1", st_addr[5], 32'hFFFF_FFFC);
    chk("t6_a2", st_addr[6], 32'h0000_0000);
    chk("t6_d2", st_data[6], 32'hA000_0002);
    chk("t6_sp", sp_last, 32'hFFFF_FFF8);
    chk("t6_done", 32'(done_cnt), 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
